// File: rtl/cplx_mul_sched.sv
// cplx_mul_sched: round-robin sequencer that shares one complex add/multiply
// datapath between two requesters. A complex multiply is spread over four
// cycles on a single real multiplier. Results go back with the requester ID
// over a valid/ready response channel.
// Optional build macro CPLX_SCHED_STATS_EN adds saturating counters of
// completed add and multiply responses (stat_add_cnt, stat_mul_cnt).
module cplx_mul_sched #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_op,
    input  logic [WIDTH-1:0]   req0_a_re,
    input  logic [WIDTH-1:0]   req0_a_im,
    input  logic [WIDTH-1:0]   req0_b_re,
    input  logic [WIDTH-1:0]   req0_b_im,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_op,
    input  logic [WIDTH-1:0]   req1_a_re,
    input  logic [WIDTH-1:0]   req1_a_im,
    input  logic [WIDTH-1:0]   req1_b_re,
    input  logic [WIDTH-1:0]   req1_b_im,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_re,
    output logic [2*WIDTH-1:0] rsp_im,
    output logic               busy
`ifdef CPLX_SCHED_STATS_EN
    ,
    output logic [15:0]        stat_add_cnt,
    output logic [15:0]        stat_mul_cnt
`endif
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_M_RR = 3'd2,
        S_M_II = 3'd3,
        S_M_RI = 3'd4,
        S_M_IR = 3'd5,
        S_RESP = 3'd6
    } state_t;

    // Sign-extend an operand component to result width. All result arithmetic
    // is done modulo 2^RW on sign-extended values, which equals the signed result.
    function automatic logic [RW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic            last_grant_r;
    logic            id_r;
    logic [WIDTH-1:0] a_re_r;
    logic [WIDTH-1:0] a_im_r;
    logic [WIDTH-1:0] b_re_r;
    logic [WIDTH-1:0] b_im_r;
    logic [RW-1:0]   acc_re_r;
    logic [RW-1:0]   acc_im_r;
    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic [RW-1:0]   rsp_re_r;
    logic [RW-1:0]   rsp_im_r;
    logic            busy_r;

    logic            grant0_s;
    logic            grant1_s;
    logic            accept_s;
    logic            accept_op_s;
    logic [WIDTH-1:0] sel_a_re_s;
    logic [WIDTH-1:0] sel_a_im_s;
    logic [WIDTH-1:0] sel_b_re_s;
    logic [WIDTH-1:0] sel_b_im_s;
    logic [WIDTH-1:0] mul_x_s;
    logic [WIDTH-1:0] mul_y_s;
    logic [RW-1:0]   prod_s;
    logic            rsp_fire_s;

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_re     = rsp_re_r;
    assign rsp_im     = rsp_im_r;
    assign busy       = busy_r;
    assign accept_s   = grant0_s | grant1_s;
    assign rsp_fire_s = (state_r == S_RESP) && rsp_ready;

    // Round-robin arbitration: only in IDLE; on contention the requester that
    // was not granted last time wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_r;
                grant1_s = ~last_grant_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Steer the granted requester's operands and op toward the capture registers.
    always_comb begin
        sel_a_re_s  = req0_a_re;
        sel_a_im_s  = req0_a_im;
        sel_b_re_s  = req0_b_re;
        sel_b_im_s  = req0_b_im;
        accept_op_s = req0_op;
        if (grant1_s) begin
            sel_a_re_s  = req1_a_re;
            sel_a_im_s  = req1_a_im;
            sel_b_re_s  = req1_b_re;
            sel_b_im_s  = req1_b_im;
            accept_op_s = req1_op;
        end else begin
            accept_op_s = req0_op;
        end
    end

    // Next-state sequencing: add takes one compute cycle, multiply four.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (accept_op_s) begin
                        state_nxt_s = S_M_RR;
                    end else begin
                        state_nxt_s = S_ADD;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ADD:  state_nxt_s = S_RESP;
            S_M_RR: state_nxt_s = S_M_II;
            S_M_II: state_nxt_s = S_M_RI;
            S_M_RI: state_nxt_s = S_M_IR;
            S_M_IR: state_nxt_s = S_RESP;
            S_RESP: begin
                if (rsp_fire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Shared multiplier input mux: one partial product per multiply state.
    always_comb begin
        mul_x_s = a_re_r;
        mul_y_s = b_re_r;
        case (state_r)
            S_M_RR: begin mul_x_s = a_re_r; mul_y_s = b_re_r; end
            S_M_II: begin mul_x_s = a_im_r; mul_y_s = b_im_r; end
            S_M_RI: begin mul_x_s = a_re_r; mul_y_s = b_im_r; end
            S_M_IR: begin mul_x_s = a_im_r; mul_y_s = b_re_r; end
            default: begin mul_x_s = a_re_r; mul_y_s = b_re_r; end
        endcase
    end

    assign prod_s = sext(mul_x_s) * sext(mul_y_s);

    // Control registers: state, fairness pointer, registered valid/busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            last_grant_r <= 1'b1;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rsp_valid_r <= (state_nxt_s == S_RESP);
            busy_r      <= (state_nxt_s != S_IDLE);
            if (accept_s) begin
                last_grant_r <= grant1_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Datapath: capture operands on accept, accumulate partial products,
    // and load the response registers on the final compute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r     <= 1'b0;
            a_re_r   <= '0;
            a_im_r   <= '0;
            b_re_r   <= '0;
            b_im_r   <= '0;
            acc_re_r <= '0;
            acc_im_r <= '0;
            rsp_id_r <= 1'b0;
            rsp_re_r <= '0;
            rsp_im_r <= '0;
        end else begin
            if (accept_s) begin
                id_r   <= grant1_s;
                a_re_r <= sel_a_re_s;
                a_im_r <= sel_a_im_s;
                b_re_r <= sel_b_re_s;
                b_im_r <= sel_b_im_s;
            end else begin
                id_r   <= id_r;
            end
            case (state_r)
                S_ADD: begin
                    rsp_id_r <= id_r;
                    rsp_re_r <= sext(a_re_r) + sext(b_re_r);
                    rsp_im_r <= sext(a_im_r) + sext(b_im_r);
                end
                S_M_RR: acc_re_r <= prod_s;
                S_M_II: acc_re_r <= acc_re_r - prod_s;
                S_M_RI: acc_im_r <= prod_s;
                S_M_IR: begin
                    rsp_id_r <= id_r;
                    rsp_re_r <= acc_re_r;
                    rsp_im_r <= acc_im_r + prod_s;
                end
                default: begin
                    acc_re_r <= acc_re_r;
                    acc_im_r <= acc_im_r;
                end
            endcase
        end
    end

`ifdef CPLX_SCHED_STATS_EN
    logic        op_r;
    logic [15:0] stat_add_r;
    logic [15:0] stat_mul_r;

    assign stat_add_cnt = stat_add_r;
    assign stat_mul_cnt = stat_mul_r;

    // Remember the op of the in-flight request so completions can be classified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
        end else if (accept_s) begin
            op_r <= accept_op_s;
        end else begin
            op_r <= op_r;
        end
    end

    // Count completed responses per op type, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_add_r <= 16'd0;
            stat_mul_r <= 16'd0;
        end else if (rsp_fire_s) begin
            if (op_r) begin
                if (stat_mul_r != 16'hFFFF) begin
                    stat_mul_r <= stat_mul_r + 16'd1;
                end else begin
                    stat_mul_r <= stat_mul_r;
                end
            end else begin
                if (stat_add_r != 16'hFFFF) begin
                    stat_add_r <= stat_add_r + 16'd1;
                end else begin
                    stat_add_r <= stat_add_r;
                end
            end
        end else begin
            stat_add_r <= stat_add_r;
            stat_mul_r <= stat_mul_r;
        end
    end
`endif

endmodule

// File: tb/tb_cplx_mul_sched.sv
// Scoreboard bench for cplx_mul_sched: accepted requests push an expected
// response computed with plain integer arithmetic; a negedge monitor checks
// responses, latency, ready arbitration, busy and reset values.
module tb_cplx_mul_sched;
    localparam int W  = 16;
    localparam int RW = 2 * W;

    typedef struct {
        bit            id;
        bit            op;
        logic [RW-1:0] re;
        logic [RW-1:0] im;
        int            acc_cyc;
        bit            seen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid [2];
    logic          req_op [2];
    logic [W-1:0]  a_re [2];
    logic [W-1:0]  a_im [2];
    logic [W-1:0]  b_re [2];
    logic [W-1:0]  b_im [2];
    logic          r0_ready;
    logic          r1_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic          busy;
    logic [RW-1:0] rsp_re;
    logic [RW-1:0] rsp_im;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_cnt [2] = '{0, 0};
    int   seen_cnt [2] = '{0, 0};
    bit   tb_last = 1'b1;
    bit   timeout_flag = 1'b0;
    bit   timeout_seen = 1'b0;
    exp_t q [$];

    cplx_mul_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req_valid[0]),
        .req0_ready (r0_ready),
        .req0_op    (req_op[0]),
        .req0_a_re  (a_re[0]),
        .req0_a_im  (a_im[0]),
        .req0_b_re  (b_re[0]),
        .req0_b_im  (b_im[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (r1_ready),
        .req1_op    (req_op[1]),
        .req1_a_re  (a_re[1]),
        .req1_a_im  (a_im[1]),
        .req1_b_re  (b_re[1]),
        .req1_b_im  (b_im[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_re     (rsp_re),
        .rsp_im     (rsp_im),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: complex add / multiply on 64-bit integers, reduced mod 2^RW.
    function automatic void model(input bit op, input logic [W-1:0] ar, input logic [W-1:0] ai,
                                  input logic [W-1:0] br, input logic [W-1:0] bi,
                                  output logic [RW-1:0] re, output logic [RW-1:0] im);
        longint xr, xi, yr, yi, r, m;
        xr = longint'($signed(ar));
        xi = longint'($signed(ai));
        yr = longint'($signed(br));
        yi = longint'($signed(bi));
        if (op) begin
            r = xr * yr - xi * yi;
            m = xr * yi + xi * yr;
        end else begin
            r = xr + yr;
            m = xi + yi;
        end
        re = r[RW-1:0];
        im = m[RW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: all comparisons happen here on the falling edge.
    initial begin : monitor
        exp_t          e;
        bit            idle;
        bit            er0;
        bit            er1;
        logic [RW-1:0] mre;
        logic [RW-1:0] mim;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                tb_last = 1'b1;
                chk("reset_rsp_valid", rsp_valid, 0);
                chk("reset_busy", busy, 0);
                chk("reset_rsp_id", rsp_id, 0);
                chk("reset_rsp_re", rsp_re, 0);
                chk("reset_rsp_im", rsp_im, 0);
            end else begin
                idle = (q.size() == 0);
                chk("busy", busy, !idle);
                if (rsp_valid) begin
                    if (idle) begin
                        chk("spurious_rsp", rsp_valid, 0);
                    end else begin
                        e = q[0];
                        if (!e.seen) begin
                            chk("latency", cyc - e.acc_cyc, e.op ? 5 : 2);
                            q[0].seen = 1'b1;
                        end
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_re", rsp_re, e.re);
                        chk("rsp_im", rsp_im, e.im);
                        if (rsp_ready) void'(q.pop_front());
                    end
                end else if (!idle && q[0].seen) begin
                    chk("rsp_valid_held", rsp_valid, 1);
                end
                er0 = idle && req_valid[0] && (!req_valid[1] || tb_last);
                er1 = idle && req_valid[1] && (!req_valid[0] || !tb_last);
                chk("req0_ready", r0_ready, er0);
                chk("req1_ready", r1_ready, er1);
                for (int k = 0; k < 2; k++) begin
                    if (idle && req_valid[k] && ((k == 0) ? r0_ready : r1_ready)) begin
                        model(req_op[k], a_re[k], a_im[k], b_re[k], b_im[k], mre, mim);
                        e.id = (k == 1);
                        e.op = req_op[k];
                        e.re = mre;
                        e.im = mim;
                        e.acc_cyc = cyc;
                        e.seen = 1'b0;
                        q.push_back(e);
                        tb_last = (k == 1);
                        acc_cnt[k]++;
                        n_vec++;
                    end
                end
            end
            if (timeout_flag && !timeout_seen) begin
                timeout_seen = 1'b1;
                n_err++;
                $display("FAIL timeout: got no completion, expected completion within budget");
            end
        end
    end

    task automatic scramble(input int k);
        a_re[k]   = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        a_im[k]   = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        b_re[k]   = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        b_im[k]   = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        req_op[k] = 1'($urandom);
    endtask

    task automatic set_req(input int k, input bit op, input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [W-1:0] br, input logic [W-1:0] bi);
        req_op[k]    = op;
        a_re[k]      = ar;
        a_im[k]      = ai;
        b_re[k]      = br;
        b_im[k]      = bi;
        req_valid[k] = 1'b1;
    endtask

    // One cycle of stimulus: drop accepted requests, scramble idle operands,
    // optionally raise new requests.
    task automatic step(input int prob, input bit refill);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc_cnt[k] != seen_cnt[k]) begin
                seen_cnt[k] = acc_cnt[k];
                req_valid[k] = 1'b0;
            end
            if (!req_valid[k]) begin
                scramble(k);
                if (refill || (int'($urandom_range(0, 99)) < prob)) req_valid[k] = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((req_valid[0] || req_valid[1] || q.size() != 0) && k < budget) begin
            step(0, 1'b0);
            k++;
        end
        if (k >= budget) timeout_flag = 1'b1;
    endtask

    initial begin : stim
        int c0;
        int k;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_op[i]    = 1'b0;
            a_re[i]      = '0;
            a_im[i]      = '0;
            b_re[i]      = '0;
            b_im[i]      = '0;
        end
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Add on requester 0: (3+4j) + (1-2j) = (4, 2)
        set_req(0, 1'b0, 16'sd3, 16'sd4, 16'sd1, -16'sd2);
        drain(40);
        // Multiply on requester 1: (3+4j)(1-2j) = (11, -2)
        set_req(1, 1'b1, 16'sd3, 16'sd4, 16'sd1, -16'sd2);
        drain(40);

        // Arbitration after reset with both requesters held valid
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 40; n++) step(0, 1'b1);
        drain(60);

        // Backpressure: response held while rsp_ready is low, req1 waiting
        rsp_ready = 1'b0;
        set_req(0, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        k = 0;
        while (!rsp_valid && k < 10) begin
            step(0, 1'b0);
            k++;
        end
        if (k >= 10) timeout_flag = 1'b1;
        set_req(1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        repeat (3) step(0, 1'b0);
        rsp_ready = 1'b1;
        drain(40);

        // Corners: all components at the most negative value
        set_req(0, 1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        drain(40);
        set_req(0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        drain(40);

        // Asynchronous reset while in M_RI: no response, req0 wins next
        set_req(0, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        c0 = acc_cnt[0];
        k = 0;
        while (acc_cnt[0] == c0 && k < 10) begin
            step(0, 1'b0);
            k++;
        end
        if (k >= 10) timeout_flag = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(1, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        set_req(0, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        drain(60);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            rsp_ready = (int'($urandom_range(0, 99)) < 70);
            step(35, 1'b0);
        end
        rsp_ready = 1'b1;
        drain(200);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
